// File: rtl/decode_sequencer.sv
// decode_sequencer: instruction queue between fetch and decode.
//
// A circular FIFO of queueDepth entries, each holding one instruction word
// and its address. Fetch pushes on a valid/ready handshake, decode pops when
// it is ready. A flush (branch redirect or exception) empties the queue and
// spends exactly one cycle in FLUSH, during which both handshakes are held low.
//
// Optional feature: define DECODE_SEQ_PERF_EN to add the stallCycles_o and
// flushCount_o performance counters.
//
// Ports:
//   clock_i               sole clock, rising edge
//   reset_i               asynchronous reset, active low
//   enable_i              global enable; low freezes all state
//   fetchValid_i          fetch presents a word this cycle
//   fetchReady_o          queue accepts the fetch word this cycle
//   instruction_i         fetched instruction (bit 0 is the MSB)
//   instructionAddress_i  address of instruction_i
//   flush_i               discard all queued entries
//   decodeReady_i         decode unit can take an instruction
//   decodeEnable_o        an instruction transfers to decode this cycle
//   instruction_o         head-of-queue instruction (zero when empty)
//   instructionAddress_o  head-of-queue address (zero when empty)
//   occupancy_o           current entry count
//   stallCycles_o         (perf) cycles with work queued but decode not ready
//   flushCount_o          (perf) number of accepted flushes
//
// State table:
//   IDLE   | queue empty
//   ACTIVE | queue holds at least one entry
//   FLUSH  | one-cycle drain after a flush; no push, no pop

module decode_sequencer #(
  parameter int instructionWidth = 32,
  parameter int addressSize      = 64,
  parameter int queueDepth       = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          fetchValid_i,
  output logic                          fetchReady_o,
  input  logic [0:instructionWidth-1]   instruction_i,
  input  logic [addressSize-1:0]        instructionAddress_i,
  input  logic                          flush_i,
  input  logic                          decodeReady_i,
  output logic                          decodeEnable_o,
  output logic [0:instructionWidth-1]   instruction_o,
  output logic [addressSize-1:0]        instructionAddress_o,
  output logic [$clog2(queueDepth):0]   occupancy_o
`ifdef DECODE_SEQ_PERF_EN
  ,
  output logic [31:0]                   stallCycles_o,
  output logic [15:0]                   flushCount_o
`endif
);

  localparam int PTR_W = $clog2(queueDepth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(queueDepth);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t                      state;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            count;
  logic [0:instructionWidth-1] instr_mem [queueDepth];
  logic [addressSize-1:0]      addr_mem  [queueDepth];

  logic push;
  logic pop;
  logic not_empty;

  assign not_empty = (count != '0);

  // Handshakes are gated by reset_i so they read zero while reset is held,
  // independent of enable_i. Fullness is judged on the current count only:
  // a pop in the same cycle does not open a slot for the fetch word.
  assign fetchReady_o   = reset_i & enable_i & (state != ST_FLUSH) & (count < DEPTH_C);
  assign decodeEnable_o = reset_i & enable_i & (state == ST_ACTIVE) & decodeReady_i & ~flush_i;

  assign push = fetchValid_i & fetchReady_o;
  assign pop  = decodeEnable_o;

  assign instruction_o        = not_empty ? instr_mem[rd_ptr] : '0;
  assign instructionAddress_o = not_empty ? addr_mem[rd_ptr]  : '0;
  assign occupancy_o          = count;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < queueDepth; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
      end
    end else if (enable_i) begin
      if (flush_i) begin
        // Flush wins over any push or pop presented in the same cycle.
        state  <= ST_FLUSH;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          instr_mem[wr_ptr] <= instruction_i;
          addr_mem[wr_ptr]  <= instructionAddress_i;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + ONE_C;
          2'b01:   count <= count - ONE_C;
          default: count <= count;
        endcase

        case (state)
          ST_IDLE: begin
            if (push) state <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (pop && !push && (count == ONE_C)) state <= ST_IDLE;
          end
          ST_FLUSH: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef DECODE_SEQ_PERF_EN
  // Saturating counters; they hold at all-ones rather than wrapping.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      stallCycles_o <= '0;
      flushCount_o  <= '0;
    end else if (enable_i) begin
      if (not_empty && !decodeReady_i && (stallCycles_o != '1)) begin
        stallCycles_o <= stallCycles_o + 32'd1;
      end
      if (flush_i && (flushCount_o != '1)) begin
        flushCount_o <= flushCount_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
module tb_decode_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fv;
  logic        fr;
  logic [0:31] instr;
  logic [63:0] addr;
  logic        fl;
  logic        dr;
  logic        de;
  logic [0:31] instr_o;
  logic [63:0] addr_o;
  logic [2:0]  occ;
`ifdef DECODE_SEQ_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  decode_sequencer #(
    .instructionWidth(32),
    .addressSize(64),
    .queueDepth(4)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .enable_i(en),
    .fetchValid_i(fv),
    .fetchReady_o(fr),
    .instruction_i(instr),
    .instructionAddress_i(addr),
    .flush_i(fl),
    .decodeReady_i(dr),
    .decodeEnable_o(de),
    .instruction_o(instr_o),
    .instructionAddress_o(addr_o),
    .occupancy_o(occ)
`ifdef DECODE_SEQ_PERF_EN
    ,
    .stallCycles_o(stall_cnt),
    .flushCount_o(flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards apply to the new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; fv = 1'b0; instr = '0; addr = '0; fl = 1'b0; dr = 1'b0;

    // Reset values
    #3;
    chk("rst_fr", 64'(fr), 64'd0);
    chk("rst_de", 64'(de), 64'd0);
    chk("rst_instr", 64'(instr_o), 64'd0);
    chk("rst_addr", addr_o, 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    #9 rst = 1'b1;
    cyc();

    // Single push, popped the following cycle
    fv = 1'b1; instr = 32'h3860_0001; addr = 64'h100; dr = 1'b1;
    #1;
    chk("single_fr", 64'(fr), 64'd1);
    chk("single_no_bypass", 64'(de), 64'd0);
    cyc();
    fv = 1'b0;
    #1;
    chk("single_de", 64'(de), 64'd1);
    chk("single_instr", 64'(instr_o), 64'h3860_0001);
    chk("single_addr", addr_o, 64'h100);
    chk("single_occ1", 64'(occ), 64'd1);
    cyc();
    #1;
    chk("single_occ0", 64'(occ), 64'd0);
    chk("single_de_off", 64'(de), 64'd0);
    chk("single_instr_zero", 64'(instr_o), 64'd0);

    // Fill with decode stalled: 5 offered, 4 accepted
    dr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fv = 1'b1; addr = 64'h200 + 64'(4 * k); instr = 32'hA000_0000 + 32'(k);
      #1;
      chk($sformatf("fill_fr%0d", k), 64'(fr), (k < 4) ? 64'd1 : 64'd0);
      cyc();
    end
    fv = 1'b0;
    #1;
    chk("fill_occ", 64'(occ), 64'd4);
    dr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k == 0) chk("full_pop_no_free", 64'(fr), 64'd0);
      chk($sformatf("drain_de%0d", k), 64'(de), 64'd1);
      chk($sformatf("drain_addr%0d", k), addr_o, 64'h200 + 64'(4 * k));
      chk($sformatf("drain_instr%0d", k), 64'(instr_o), 64'hA000_0000 + 64'(k));
      chk($sformatf("drain_occ%0d", k), 64'(occ), 64'(4 - k));
      cyc();
    end
    #1;
    chk("drain_empty", 64'(occ), 64'd0);

    // Flush at occupancy 2 with a push offered
    dr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fv = 1'b1; addr = 64'h300 + 64'(4 * k);
      cyc();
    end
    fv = 1'b0;
    #1;
    chk("preflush_occ", 64'(occ), 64'd2);
    fl = 1'b1; fv = 1'b1;
    cyc();
    fl = 1'b0; dr = 1'b1;
    #1;
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_fr", 64'(fr), 64'd0);
    chk("flush_de", 64'(de), 64'd0);
    cyc();
    fv = 1'b0;
    #1;
    chk("postflush_idle_fr", 64'(fr), 64'd1);
    chk("postflush_occ", 64'(occ), 64'd0);

    // Streaming push+pop with pointer wrap
    fv = 1'b1; addr = 64'h0; dr = 1'b1;
    cyc();
    for (int k = 1; k <= 10; k++) begin
      fv = 1'b1; addr = 64'(4 * k);
      #1;
      chk($sformatf("stream_de%0d", k), 64'(de), 64'd1);
      chk($sformatf("stream_addr%0d", k), addr_o, 64'(4 * (k - 1)));
      chk($sformatf("stream_occ%0d", k), 64'(occ), 64'd1);
      cyc();
    end
    fv = 1'b0; dr = 1'b0;
    #1;
    chk("stream_tail_addr", addr_o, 64'h28);

    // Asynchronous reset at occupancy 3
    for (int k = 0; k < 2; k++) begin
      fv = 1'b1; addr = 64'h400 + 64'(4 * k);
      cyc();
    end
    fv = 1'b0; dr = 1'b1;
    #1;
    chk("prereset_occ", 64'(occ), 64'd3);
    chk("prereset_de", 64'(de), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("areset_occ", 64'(occ), 64'd0);
    chk("areset_de", 64'(de), 64'd0);
    chk("areset_fr", 64'(fr), 64'd0);
    chk("areset_instr", 64'(instr_o), 64'd0);
    chk("areset_addr", addr_o, 64'd0);
    rst = 1'b1;
    cyc();
    #1;
    chk("postreset_occ", 64'(occ), 64'd0);

    // Enable low freezes everything
    fv = 1'b1; addr = 64'h500; dr = 1'b0;
    cyc();
    en = 1'b0; fv = 1'b1; dr = 1'b1;
    #1;
    chk("dis_fr", 64'(fr), 64'd0);
    chk("dis_de", 64'(de), 64'd0);
    cyc();
    en = 1'b1; fv = 1'b0; dr = 1'b0;
    #1;
    chk("dis_occ_hold", 64'(occ), 64'd1);
    chk("dis_addr_hold", addr_o, 64'h500);

`ifdef DECODE_SEQ_PERF_EN
    // Fresh counters: 7 stalled cycles, then 2 flushes
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    cyc();
    fv = 1'b1; addr = 64'h600; dr = 1'b0;
    cyc();
    fv = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    dr = 1'b1; fl = 1'b1;
    cyc();
    cyc();
    fl = 1'b0;
    cyc();
    #1;
    chk("perf_stall", 64'(stall_cnt), 64'd7);
    chk("perf_flush", 64'(flush_cnt), 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
